// File: rtl/apb_fnd_ctrl_if.sv
// APB bus bundle shared by the FND controller (slave side) and whatever master drives it.
interface apb_fnd_ctrl_if;
    logic [3:0]  PADDR;
    logic [31:0] PWDATA;
    logic        PWRITE;
    logic        PENABLE;
    logic        PSEL;
    logic [31:0] PRDATA;
    logic        PREADY;

    modport master (output PADDR, PWDATA, PWRITE, PENABLE, PSEL, input PRDATA, PREADY);
    modport slave  (input PADDR, PWDATA, PWRITE, PENABLE, PSEL, output PRDATA, PREADY);
endinterface

// File: rtl/apb_fnd_ctrl.sv
// APB seven-segment controller: register file, sequential binary-to-BCD converter and digit scanner.
// Optional display blink is compiled in when FND_BLINK_EN is defined.
//
// state  | meaning
// S_IDLE | shadow register holds the last completed result
// S_CONV | shift-add-3 iterations running, one bit per cycle
// S_DONE | result copied into the display shadow register
module apb_fnd_ctrl #(
    parameter int NUM_DIGITS   = 4,
    parameter int SCAN_DIV_W   = 17,
    parameter int SCAN_DEFAULT = 99_999
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    apb_fnd_ctrl_if.slave         apb,
    output logic [NUM_DIGITS-1:0] fnd_comm,
    output logic [7:0]            fnd_font
);
    localparam int BW = 4 * NUM_DIGITS;
    localparam int CW = $clog2(BW);
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    function automatic logic [BW-1:0] dec_max();
        logic [BW+3:0] v;
        v = (BW+4)'(1);
        for (int i = 0; i < NUM_DIGITS; i++) v = v * (BW+4)'(10);
        return BW'(v - (BW+4)'(1));
    endfunction

    localparam logic [BW-1:0] DEC_MAX = dec_max();

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'h0: seg7 = 7'h40;  4'h1: seg7 = 7'h79;  4'h2: seg7 = 7'h24;  4'h3: seg7 = 7'h30;
            4'h4: seg7 = 7'h19;  4'h5: seg7 = 7'h12;  4'h6: seg7 = 7'h02;  4'h7: seg7 = 7'h78;
            4'h8: seg7 = 7'h00;  4'h9: seg7 = 7'h10;  4'hA: seg7 = 7'h08;  4'hB: seg7 = 7'h03;
            4'hC: seg7 = 7'h46;  4'hD: seg7 = 7'h21;  4'hE: seg7 = 7'h06;  default: seg7 = 7'h0E;
        endcase
    endfunction

    typedef enum logic [1:0] {S_IDLE, S_CONV, S_DONE} state_t;

    logic                  pready_q;
    logic [31:0]           prdata_q;
    logic                  cr_en_q, cr_hex_q, cr_lzb_q;
    logic [BW-1:0]         dr_q;
    logic [NUM_DIGITS-1:0] dpr_q;
    logic [SCAN_DIV_W-1:0] sdr_q;

    state_t                state_q, state_d;
    logic [BW-1:0]         bin_q, bin_d, bcd_q, bcd_d, bcd_adj;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  conv_hex_q, conv_hex_d, conv_ovf_q, conv_ovf_d;
    logic                  shd_load;

    logic [BW-1:0]         shd_val_q;
    logic                  shd_dec_q, shd_ovf_q;

    logic [SCAN_DIV_W-1:0] scan_cnt_q;
    logic [IW-1:0]         idx_q;
    logic                  tick;

    logic [NUM_DIGITS-1:0] comm_q, comm_d;
    logic [7:0]            font_q, font_d;

    logic                  commit, wr_en, wr_cr, wr_dr, wr_dpr, wr_sdr, start;
    logic [1:0]            reg_sel;
    logic [31:0]           rd_data;
    logic                  busy, blink_bit, blink_off;
    logic [BW-1:0]         load_val;
    logic                  load_hex;
    logic                  unused_bits;

    // One wait state: PREADY itself blocks a second commit on the following edge.
    assign commit  = apb.PSEL & apb.PENABLE & ~pready_q;
    assign wr_en   = commit & apb.PWRITE;
    assign reg_sel = apb.PADDR[3:2];
    assign wr_cr   = wr_en && (reg_sel == 2'd0);
    assign wr_dr   = wr_en && (reg_sel == 2'd1);
    assign wr_dpr  = wr_en && (reg_sel == 2'd2);
    assign wr_sdr  = wr_en && (reg_sel == 2'd3);
    assign start   = wr_dr | wr_cr;
    assign busy    = (state_q != S_IDLE);

    assign apb.PREADY = pready_q;
    assign apb.PRDATA = prdata_q;
    assign unused_bits = ^{apb.PADDR[1:0], apb.PWDATA};

    always_comb begin
        rd_data = '0;
        case (reg_sel)
            2'd0:    rd_data = {busy, 27'b0, blink_bit, cr_lzb_q, cr_hex_q, cr_en_q};
            2'd1:    rd_data[BW-1:0] = dr_q;
            2'd2:    rd_data[NUM_DIGITS-1:0] = dpr_q;
            default: rd_data[SCAN_DIV_W-1:0] = sdr_q;
        endcase
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            pready_q <= 1'b0;
            prdata_q <= '0;
            cr_en_q  <= 1'b0;
            cr_hex_q <= 1'b0;
            cr_lzb_q <= 1'b0;
            dr_q     <= '0;
            dpr_q    <= '0;
            sdr_q    <= SCAN_DIV_W'(SCAN_DEFAULT);
        end else begin
            pready_q <= commit;
            if (commit) prdata_q <= rd_data;
            if (wr_cr) begin
                cr_en_q  <= apb.PWDATA[0];
                cr_hex_q <= apb.PWDATA[1];
                cr_lzb_q <= apb.PWDATA[2];
            end
            if (wr_dr)  dr_q  <= apb.PWDATA[BW-1:0];
            if (wr_dpr) dpr_q <= apb.PWDATA[NUM_DIGITS-1:0];
            if (wr_sdr) sdr_q <= apb.PWDATA[SCAN_DIV_W-1:0];
        end
    end

    // A DR write converts the value being written, not the stale register contents.
    assign load_val = wr_dr ? apb.PWDATA[BW-1:0] : dr_q;
    assign load_hex = wr_cr ? apb.PWDATA[1] : cr_hex_q;

    always_comb begin
        bcd_adj = bcd_q;
        for (int d = 0; d < NUM_DIGITS; d++)
            if (bcd_q[4*d +: 4] >= 4'd5) bcd_adj[4*d +: 4] = bcd_q[4*d +: 4] + 4'd3;
    end

    always_comb begin
        state_d    = state_q;
        bin_d      = bin_q;
        bcd_d      = bcd_q;
        cnt_d      = cnt_q;
        conv_hex_d = conv_hex_q;
        conv_ovf_d = conv_ovf_q;
        shd_load   = 1'b0;
        case (state_q)
            S_CONV: begin
                bin_d = bin_q << 1;
                bcd_d = {bcd_adj[BW-2:0], bin_q[BW-1]};
                if (cnt_q == '0) state_d = S_DONE;
                else             cnt_d   = cnt_q - CW'(1);
            end
            S_DONE: begin
                shd_load = 1'b1;
                state_d  = S_IDLE;
            end
            default: ;
        endcase
        // DONE above still publishes the old result when a restart lands on it.
        if (start) begin
            bin_d      = load_val;
            bcd_d      = '0;
            cnt_d      = CW'(BW - 1);
            conv_hex_d = load_hex;
            conv_ovf_d = ~load_hex & (load_val > DEC_MAX);
            state_d    = load_hex ? S_DONE : S_CONV;
        end
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q    <= S_IDLE;
            bin_q      <= '0;
            bcd_q      <= '0;
            cnt_q      <= '0;
            conv_hex_q <= 1'b0;
            conv_ovf_q <= 1'b0;
            shd_val_q  <= '0;
            shd_dec_q  <= 1'b0;
            shd_ovf_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            bin_q      <= bin_d;
            bcd_q      <= bcd_d;
            cnt_q      <= cnt_d;
            conv_hex_q <= conv_hex_d;
            conv_ovf_q <= conv_ovf_d;
            if (shd_load) begin
                shd_val_q <= conv_hex_q ? bin_q : bcd_q;
                shd_dec_q <= ~conv_hex_q;
                shd_ovf_q <= conv_ovf_q;
            end
        end
    end

    assign tick = (scan_cnt_q == '0);

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            scan_cnt_q <= SCAN_DIV_W'(SCAN_DEFAULT);
            idx_q      <= '0;
        end else begin
            if (wr_sdr)    scan_cnt_q <= apb.PWDATA[SCAN_DIV_W-1:0];
            else if (tick) scan_cnt_q <= sdr_q;
            else           scan_cnt_q <= scan_cnt_q - SCAN_DIV_W'(1);
            if (tick) idx_q <= (idx_q == IW'(NUM_DIGITS - 1)) ? '0 : idx_q + IW'(1);
        end
    end

`ifdef FND_BLINK_EN
    logic       cr_blink_q, blink_on_q;
    logic [7:0] blink_cnt_q;

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            cr_blink_q  <= 1'b0;
            blink_on_q  <= 1'b0;
            blink_cnt_q <= '0;
        end else begin
            if (wr_cr) cr_blink_q <= apb.PWDATA[3];
            if (!cr_blink_q) begin
                blink_on_q  <= 1'b0;
                blink_cnt_q <= '0;
            end else if (tick) begin
                blink_cnt_q <= blink_cnt_q + 8'd1;
                if (blink_cnt_q == 8'hFF) blink_on_q <= ~blink_on_q;
            end
        end
    end

    assign blink_bit = cr_blink_q;
    assign blink_off = cr_blink_q & ~blink_on_q;
`else
    assign blink_bit = 1'b0;
    assign blink_off = 1'b0;
`endif

    always_comb begin
        logic [BW-1:0] shifted;
        logic [6:0]    seg;
        shifted = shd_val_q >> {idx_q, 2'b00};
        seg     = seg7(shifted[3:0]);
        if (shd_dec_q && shd_ovf_q)
            seg = 7'h3F;
        else if (shd_dec_q && cr_lzb_q && (idx_q != '0) && (shifted == '0))
            seg = 7'h7F;
        font_d = {~dpr_q[idx_q], seg};
        comm_d = ~(NUM_DIGITS'(1) << idx_q);
        if (!cr_en_q || blink_off) comm_d = '1;
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            comm_q <= '1;
            font_q <= 8'hFF;
        end else begin
            comm_q <= comm_d;
            font_q <= font_d;
        end
    end

    assign fnd_comm = comm_q;
    assign fnd_font = font_q;
endmodule

// File: tb/tb_apb_fnd_ctrl.sv
// Self-checking bench for apb_fnd_ctrl: register reads and scan outputs checked through scoreboards.
module tb_apb_fnd_ctrl;
    localparam int N = 4;
    localparam logic [3:0] A_CR = 4'h0, A_DR = 4'h4, A_DPR = 4'h8, A_SDR = 4'hC;

    typedef struct packed {
        logic [N-1:0] comm;
        logic [7:0]   font;
    } scan_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] fnd_comm;
    logic [7:0]   fnd_font;

    int errors = 0;
    int checks = 0;
    logic [31:0] rd_exp_q[$];
    scan_t       scan_exp_q[$];
    logic        mon_en = 1'b0;
    int          bad_cnt = 0;

    apb_fnd_ctrl_if bus();

    apb_fnd_ctrl #(.NUM_DIGITS(N), .SCAN_DIV_W(17), .SCAN_DEFAULT(99_999)) dut (
        .PCLK(clk), .PRESET(rst), .apb(bus), .fnd_comm(fnd_comm), .fnd_font(fnd_font)
    );

    always #5 clk = ~clk;

    always @(negedge clk)
        if (mon_en && (fnd_font inside {8'hF9, 8'hA4, 8'hB0, 8'h99})) bad_cnt++;

    task automatic apb_xfer(input logic wr, input logic [3:0] addr, input logic [31:0] wdata,
                            output logic [31:0] rdata);
        int n;
        @(negedge clk);
        bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = wr; bus.PADDR = addr; bus.PWDATA = wdata;
        @(negedge clk);
        bus.PENABLE = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!bus.PREADY && n < 20);
        rdata = bus.PREADY ? bus.PRDATA : 'x;
        if (!bus.PREADY) begin
            checks++; errors++;
            $display("FAIL apb_timeout addr=%h", addr);
        end
        bus.PSEL = 1'b0; bus.PENABLE = 1'b0;
    endtask

    task automatic wr(input logic [3:0] addr, input logic [31:0] data);
        logic [31:0] d;
        apb_xfer(1'b1, addr, data, d);
    endtask

    // Edges from the commit edge (counted as 1) until BUSY is seen low.
    task automatic wait_conv(output int n);
        n = 1;
        while (dut.busy && n < 100) begin @(negedge clk); n++; end
    endtask

    task automatic push_scan(input logic [7:0] f0, f1, f2, f3);
        logic [7:0] f[4];
        f = '{f0, f1, f2, f3};
        for (int k = 0; k < 8; k++) scan_exp_q.push_back({~(N'(1) << (k % 4)), f[k % 4]});
    endtask

    task automatic scan_collect(input int period, output scan_t obs[8]);
        logic [N-1:0] prev;
        logic         found;
        prev  = fnd_comm;
        found = 1'b0;
        for (int n = 0; n < 200 && !found; n++) begin
            @(negedge clk);
            found = (fnd_comm == ~N'(1)) && (prev != ~N'(1));
            prev  = fnd_comm;
        end
        for (int k = 0; k < 8; k++) begin
            if (k > 0) repeat (period) @(negedge clk);
            obs[k] = found ? {fnd_comm, fnd_font} : 'x;
        end
    endtask

    task automatic test_reset;
        logic [31:0] rd, ex;
        logic [31:0] addrs[3];
        repeat (3) @(negedge clk);
        checks++; if (fnd_comm !== 4'hF) begin errors++; $display("FAIL reset_comm got=%h exp=f", fnd_comm); end
        checks++; if (fnd_font !== 8'hFF) begin errors++; $display("FAIL reset_font got=%h exp=ff", fnd_font); end
        checks++; if (bus.PREADY !== 1'b0) begin errors++; $display("FAIL reset_pready got=%b exp=0", bus.PREADY); end
        checks++; if (bus.PRDATA !== 32'h0) begin errors++; $display("FAIL reset_prdata got=%h exp=0", bus.PRDATA); end
        rst = 1'b0;
        addrs = '{A_SDR, A_CR, A_DPR};
        rd_exp_q.push_back(32'd99_999);
        rd_exp_q.push_back(32'h0);
        rd_exp_q.push_back(32'h0);
        foreach (addrs[i]) begin
            apb_xfer(1'b0, addrs[i][3:0], 32'h0, rd);
            ex = rd_exp_q.pop_front();
            checks++;
            if (rd !== ex) begin errors++; $display("FAIL reset_read[%0d] got=%h exp=%h", i, rd, ex); end
        end
    endtask

    task automatic test_hex;
        int n;
        scan_t obs[8], s;
        logic [31:0] rd, ex;
        wr(A_CR, 32'h3);
        wait_conv(n);
        checks++; if (n !== 2) begin errors++; $display("FAIL hex_cr_busy got=%0d exp=2", n); end
        wr(A_SDR, 32'd3);
        wr(A_DR, 32'h12AF);
        wait_conv(n);
        checks++; if (n !== 2) begin errors++; $display("FAIL hex_dr_busy got=%0d exp=2", n); end
        rd_exp_q.push_back(32'h12AF);
        apb_xfer(1'b0, A_DR, 32'h0, rd);
        ex = rd_exp_q.pop_front();
        checks++; if (rd !== ex) begin errors++; $display("FAIL hex_dr_read got=%h exp=%h", rd, ex); end
        push_scan(8'h8E, 8'h88, 8'hA4, 8'hF9);
        scan_collect(4, obs);
        foreach (obs[k]) begin
            s = scan_exp_q.pop_front(); checks++;
            if (obs[k] !== s) begin errors++;
                $display("FAIL hex_scan[%0d] got=%h/%h exp=%h/%h", k, obs[k].comm, obs[k].font, s.comm, s.font); end
        end
    endtask

    task automatic test_decimal;
        int n;
        scan_t obs[8], s;
        wr(A_CR, 32'h5);
        wait_conv(n);
        checks++; if (n !== 18) begin errors++; $display("FAIL dec_cr_busy got=%0d exp=18", n); end
        wr(A_DR, 32'd42);
        wait_conv(n);
        checks++; if (n !== 18) begin errors++; $display("FAIL dec_dr_busy got=%0d exp=18", n); end
        wr(A_DPR, 32'h2);
        push_scan(8'hA4, 8'h19, 8'hFF, 8'hFF);
        scan_collect(4, obs);
        foreach (obs[k]) begin
            s = scan_exp_q.pop_front(); checks++;
            if (obs[k] !== s) begin errors++;
                $display("FAIL dec_lzb_scan[%0d] got=%h/%h exp=%h/%h", k, obs[k].comm, obs[k].font, s.comm, s.font); end
        end
        wr(A_CR, 32'h1);
        wait_conv(n);
        push_scan(8'hA4, 8'h19, 8'hC0, 8'hC0);
        scan_collect(4, obs);
        foreach (obs[k]) begin
            s = scan_exp_q.pop_front(); checks++;
            if (obs[k] !== s) begin errors++;
                $display("FAIL dec_nolzb_scan[%0d] got=%h/%h exp=%h/%h", k, obs[k].comm, obs[k].font, s.comm, s.font); end
        end
    endtask

    task automatic test_overflow;
        int n;
        scan_t obs[8], s;
        logic [31:0] vals[3];
        logic [7:0]  f[3][4];
        wr(A_DPR, 32'h0);
        vals = '{32'd10000, 32'd9999, 32'd0};
        f    = '{'{8'hBF, 8'hBF, 8'hBF, 8'hBF}, '{8'h90, 8'h90, 8'h90, 8'h90}, '{8'hC0, 8'hFF, 8'hFF, 8'hFF}};
        foreach (vals[v]) begin
            if (v == 2) begin wr(A_CR, 32'h5); wait_conv(n); end
            wr(A_DR, vals[v]);
            wait_conv(n);
            push_scan(f[v][0], f[v][1], f[v][2], f[v][3]);
            scan_collect(4, obs);
            foreach (obs[k]) begin
                s = scan_exp_q.pop_front(); checks++;
                if (obs[k] !== s) begin errors++;
                    $display("FAIL ovf_scan[%0d][%0d] got=%h/%h exp=%h/%h", v, k, obs[k].comm, obs[k].font, s.comm, s.font); end
            end
        end
    endtask

    task automatic test_restart;
        int n;
        scan_t obs[8], s;
        logic [31:0] rd, ex;
        bad_cnt = 0;
        mon_en  = 1'b1;
        wr(A_DR, 32'd1234);
        rd_exp_q.push_back(32'h8000_0005);
        apb_xfer(1'b0, A_CR, 32'h0, rd);
        ex = rd_exp_q.pop_front();
        checks++; if (rd !== ex) begin errors++; $display("FAIL restart_busy_read got=%h exp=%h", rd, ex); end
        wr(A_DR, 32'd5678);
        wait_conv(n);
        checks++; if (n !== 18) begin errors++; $display("FAIL restart_busy got=%0d exp=18", n); end
        push_scan(8'h80, 8'hF8, 8'h82, 8'h92);
        scan_collect(4, obs);
        foreach (obs[k]) begin
            s = scan_exp_q.pop_front(); checks++;
            if (obs[k] !== s) begin errors++;
                $display("FAIL restart_scan[%0d] got=%h/%h exp=%h/%h", k, obs[k].comm, obs[k].font, s.comm, s.font); end
        end
        mon_en = 1'b0;
        checks++; if (bad_cnt !== 0) begin errors++; $display("FAIL restart_stale got=%0d exp=0", bad_cnt); end
    endtask

    task automatic test_reset_mid;
        logic [31:0] rd, ex;
        wr(A_DR, 32'd77);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        checks++; if (dut.busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got=%b exp=0", dut.busy); end
        checks++; if (fnd_comm !== 4'hF) begin errors++; $display("FAIL rstmid_comm got=%h exp=f", fnd_comm); end
        checks++; if (fnd_font !== 8'hFF) begin errors++; $display("FAIL rstmid_font got=%h exp=ff", fnd_font); end
        @(negedge clk);
        rst = 1'b0;
        rd_exp_q.push_back(32'd99_999);
        apb_xfer(1'b0, A_SDR, 32'h0, rd);
        ex = rd_exp_q.pop_front();
        checks++; if (rd !== ex) begin errors++; $display("FAIL rstmid_sdr got=%h exp=%h", rd, ex); end
    endtask

    task automatic test_blink;
        logic [31:0] rd, ex;
`ifdef FND_BLINK_EN
        int n_on, n_off, w;
        wr(A_SDR, 32'd0);
        wr(A_CR, 32'h9);
        w = 0;
        while (fnd_comm == '1 && w < 600) begin @(negedge clk); w++; end
        n_on = 0;
        while (fnd_comm != '1 && n_on < 600) begin @(negedge clk); n_on++; end
        n_off = 0;
        while (fnd_comm == '1 && n_off < 600) begin @(negedge clk); n_off++; end
        checks++; if (n_on !== 256) begin errors++; $display("FAIL blink_on got=%0d exp=256", n_on); end
        checks++; if (n_off !== 256) begin errors++; $display("FAIL blink_off got=%0d exp=256", n_off); end
        rd_exp_q.push_back(32'h9);
        apb_xfer(1'b0, A_CR, 32'h0, rd);
`else
        wr(A_CR, 32'hF);
        rd_exp_q.push_back(32'h7);
        apb_xfer(1'b0, A_CR, 32'h0, rd);
`endif
        ex = rd_exp_q.pop_front();
        checks++; if (rd !== ex) begin errors++; $display("FAIL blink_cr_read got=%h exp=%h", rd, ex); end
    endtask

    initial begin
        bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0; bus.PADDR = '0; bus.PWDATA = '0;
        test_reset();
        test_hex();
        test_decimal();
        test_overflow();
        test_restart();
        test_reset_mid();
        test_blink();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500_000;
        $display("FAIL watchdog expired");
        $fatal(1, "bench watchdog");
    end
endmodule

// File: doc/apb_fnd_ctrl.md
# apb_fnd_ctrl

APB-slave seven-segment display controller: a parametrised successor to the fixed 4-digit FND counter peripheral. It supports a configurable digit count, decimal or raw-hex display, per-digit decimal points, leading-zero blanking, a software-programmable scan rate and an overflow indication. Binary-to-BCD conversion is a sequential shift-add-3 engine, so the displayed value never shows a partially converted result. It sits on the APB peripheral bus and drives the board FND pins directly.

## Interface
- NUM_DIGITS, 4, digits driven (1..8); BW = 4*NUM_DIGITS is the data width.
- SCAN_DIV_W, 17, scan divisor register width.
- SCAN_DEFAULT, 99_999, SDR reset value (1 kHz digit rate at 100 MHz).
- PCLK  in  1  clock. Reset is PRESET, asynchronous, active-high; clock is PCLK.
- PRESET  in  1  reset.
- PADDR  in  4  byte address; PADDR[3:2] selects the register.
- PWDATA  in  32  write data.
- PWRITE, PENABLE, PSEL  in  1 each  APB controls.
- PRDATA  out  32  read data (registered).
- PREADY  out  1  transfer complete (registered).
- fnd_comm  out  NUM_DIGITS  digit enables, active-low.
- fnd_font  out  8  segments {dp,g..a}, active-low.

## Operation
- Registers:
  - 0x0 CR: bit0 EN, bit1 HEX, bit2 LZB (leading-zero blank), bit3 BLINK (macro only), bit31 BUSY (read-only). Unused bits read 0.
  - 0x4 DR: [BW-1:0] value.
  - 0x8 DPR: [NUM_DIGITS-1:0] decimal points, 1 = lit.
  - 0xC SDR: [SCAN_DIV_W-1:0] divisor.
  - All registers reset to 0, except SDR, which resets to SCAN_DEFAULT.
- APB commit: a write or read commits on the edge where PSEL&PENABLE&!PREADY. That same edge sets PREADY=1 and loads PRDATA. PREADY returns to 0 on the next edge. This gives one wait state and exactly one commit per transfer.
- Converter FSM, states IDLE, CONV, DONE:
  - A commit to DR or CR enters CONV, loading the shift register from DR. This applies from any state; the latest value wins and an in-progress conversion restarts.
  - HEX=1: CONV is skipped and the FSM enters DONE directly.
  - HEX=0: CONV runs BW shift-add-3 iterations over NUM_DIGITS BCD digits, then enters DONE.
  - DONE loads the display shadow register and returns to IDLE.
  - BUSY = (state != IDLE).
- Overflow: when HEX=0 and DR > 10^NUM_DIGITS-1 (compared against an elaboration-time constant), every digit shows a dash, font 8'hBF. DP is still applied.
- LZB, decimal mode only: digits above the most significant non-zero digit blank to 8'hFF. Digit 0 is never blanked. DP is still applied to blanked digits.
- Font table: 0-9 = C0,F9,A4,B0,99,92,82,F8,80,90; A-F = 88,83,C6,A1,86,8E. Bit7 of the font = ~DPR[idx].
- Scan:
  - The tick counter reloads on reaching SDR, giving a tick every SDR+1 cycles; SDR=0 ticks every cycle.
  - Writing SDR resets the tick counter.
  - On each tick, idx steps 0..NUM_DIGITS-1 and wraps to 0.
  - fnd_comm = ~(1<<idx) when EN=1, all ones when EN=0. fnd_font is still driven when EN=0.

## Timing
- Reset values: fnd_comm all 1, fnd_font 8'hFF, PRDATA 0, PREADY 0, FSM IDLE, idx 0, shadow register all-zero digits.
- fnd_comm and fnd_font are registered and update one edge after idx or the shadow register changes.
- Shadow update latency from the commit edge: HEX mode, 2 edges; decimal mode, BW+2 edges (18 for NUM_DIGITS=4).
- Reset asserted mid-conversion aborts it; the shadow register and outputs return to their reset values.
- A DR write concurrent with the DONE state: DONE still loads the old result, then a new CONV starts.

## Configuration
- FND_BLINK_EN defined:
  - CR bit3 is implemented.
  - When BLINK=1, an 8-bit counter of scan ticks toggles the blink phase on each wrap.
  - During the off phase, fnd_comm is all ones.
- FND_BLINK_EN undefined: CR bit3 writes are ignored, the bit reads 0, and no blink logic is present.

## Test plan
- Reset → fnd_comm=4'hF, fnd_font=8'hFF, PREADY=0. Read SDR → 99_999.
- HEX mode:
  - Stimulus: CR=0x3, SDR=3, DR=0x12AF.
  - Expected: BUSY clears after 2 edges. Digits 0..3 show 8E, 88, A4, F9, with fnd_comm cycling E,D,B,7 every 4 cycles.
- Decimal mode:
  - Stimulus: CR=0x5, DR=42, DPR=0x2.
  - Expected: BUSY is high for 18 edges. Digit0=A4, digit1=19 (4 with DP), digits 2-3 = FF.
- Overflow:
  - Stimulus: DR=10000, NUM_DIGITS=4.
  - Expected: all digits BF. Then DR=9999 → all digits 90.
- Restart: DR=1234, then DR=5678 mid-conversion → the shadow register shows only 5678; 1234 never appears on fnd_font.
- Blink (FND_BLINK_EN defined):
  - Stimulus: CR=0x9, SDR=0.
  - Expected: fnd_comm is all ones for 256 ticks, then scans for 256 ticks. APB read of CR with the macro undefined → bit3=0.
